sw_debouncer: RTL

// - Upstream stage of SWDriver: conditions the 16 raw board slide switches before SWDriver zero-extends them onto the 32-bit read bus.
// - Per bit: 2-flop synchronizer, then a saturating debounce counter.
// - Outputs a clean SW[15:0] word and a one-cycle change strobe with a mask of the flipped bits.

---
 rtl/sw_debouncer.sv | 92 +++++++++
 1 files changed

// File: rtl/sw_debouncer.sv
// Per-bit 2-flop synchronizer plus saturating debounce counter for the board slide switches.
// Optional sticky rising-edge flags are built when SW_DEB_EDGE_LATCH_EN is defined.
module sw_debouncer #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SW_RAW,
    output logic [WIDTH-1:0] SW,
    output logic             SW_CHG,
    output logic [WIDTH-1:0] SW_CHG_MASK
`ifdef SW_DEB_EDGE_LATCH_EN
    ,
    input  logic [WIDTH-1:0] EDGE_CLR,
    output logic [WIDTH-1:0] EDGE_LATCH
`endif
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic             chg_q, chg_d;
    logic [WIDTH-1:0] chg_mask_q, chg_mask_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bit only commits after DEBOUNCE_CYCLES consecutive mismatches; any match restarts it.
    always_comb begin
        sw_d = sw_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != sw_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sw_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        chg_mask_d = sw_d ^ sw_q;
        chg_d      = |chg_mask_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sw_q       <= '0;
            chg_q      <= 1'b0;
            chg_mask_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= SW_RAW;
            sync2_q    <= sync1_q;
            sw_q       <= sw_d;
            chg_q      <= chg_d;
            chg_mask_q <= chg_mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign SW          = sw_q;
    assign SW_CHG      = chg_q;
    assign SW_CHG_MASK = chg_mask_q;

`ifdef SW_DEB_EDGE_LATCH_EN
    logic [WIDTH-1:0] edge_q, edge_d;

    // Set term is OR-ed after the clear so a same-cycle rising flip wins.
    always_comb begin
        edge_d = (edge_q & ~EDGE_CLR) | (chg_mask_d & sw_d);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign EDGE_LATCH = edge_q;
`endif

endmodule
